// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions
// Purpose: state encoding and default frame parameters shared by the
//          UART receiver and transmitter.
// Ports:   none (package)
package uart_pkg;

   // Encoding is shared with the transmitter; keep the values fixed.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_e;

   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_NBITS_DATA = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
// Purpose: brings an asynchronous level into the i_clk domain.
// Ports:   i_clk   - destination clock
//          i_reset - synchronous, active-high reset (both flops load RST_VAL)
//          i_d     - asynchronous input
//          o_q     - synchronized output, 2 i_clk cycles of latency
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver
// Purpose: samples the serial line on baud-rate ticks and assembles
//          LSB-first frames (start, NBITS_DATA data bits, stop).
// Ports:   i_clk       - system clock
//          i_reset     - synchronous, active-high reset
//          i_rx        - asynchronous serial line, idle high
//          i_tick_brg  - oversample tick, one i_clk cycle wide
//          o_data      - last received word, held until the next frame
//          o_rx_done   - one-cycle pulse when o_data/o_frame_err update
//          o_frame_err - stop bit sampled low on the last frame
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned NBITS_DATA   = UART_NBITS_DATA,
   parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
   parameter int unsigned STOPBITS_TCK = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_rx,
   input  logic                  i_tick_brg,
   output logic [NBITS_DATA-1:0] o_data,
   output logic                  o_rx_done,
   output logic                  o_frame_err
);

   localparam int unsigned TW = max_u($clog2(max_u(OVERSAMPLE, STOPBITS_TCK)), 1);
   localparam int unsigned BW = max_u($clog2(NBITS_DATA), 1);

   localparam logic [TW-1:0] TCK_MID_START = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TCK_BIT_END   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TCK_STOP_END  = TW'(STOPBITS_TCK - 1);
   localparam logic [BW-1:0] BIT_LAST      = BW'(NBITS_DATA - 1);

   logic rx_s;

   uart_state_e             state_q,     state_d;
   logic [TW-1:0]           tick_cnt_q,  tick_cnt_d;
   logic [BW-1:0]           bit_cnt_q,   bit_cnt_d;
   logic [NBITS_DATA-1:0]   shreg_q,     shreg_d;
   logic [NBITS_DATA-1:0]   data_q,      data_d;
   logic                    rx_done_q,   rx_done_d;
   logic                    frame_err_q, frame_err_d;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      rx_done_d   = 1'b0;
      frame_err_d = frame_err_q;

      unique case (state_q)
         // Start edge is looked for on every clock so the start-bit timing
         // does not lose up to a whole tick period.
         IDLE: begin
            if (!rx_s) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end

         // Re-check the line at the middle of the start bit; a high level
         // there means the falling edge was a glitch.
         START: begin
            if (i_tick_brg) begin
               if (tick_cnt_q == TCK_MID_START) begin
                  if (!rx_s) begin
                     state_d    = DATA;
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                  end else begin
                     state_d    = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         // Sampling a full bit period after mid-start lands every data
         // sample in the middle of its bit.
         DATA: begin
            if (i_tick_brg) begin
               if (tick_cnt_q == TCK_BIT_END) begin
                  tick_cnt_d = '0;
                  shreg_d    = {rx_s, shreg_q[NBITS_DATA-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         // A low stop bit is reported, not recovered from: the word is still
         // delivered and the FSM simply returns to IDLE.
         STOP: begin
            if (i_tick_brg) begin
               if (tick_cnt_q == TCK_STOP_END) begin
                  data_d      = shreg_q;
                  frame_err_d = ~rx_s;
                  rx_done_d   = 1'b1;
                  state_d     = IDLE;
                  tick_cnt_d  = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_data      = data_q;
   assign o_rx_done   = rx_done_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive side of the team's 16x-oversampled UART.
- Samples the serial line on baud-rate-generator ticks (one tick = 1/16 bit time) and assembles LSB-first frames.
- Frame format: 1 start bit, NBITS_DATA data bits, 1 stop bit.
- Delivers each received word with a one-cycle done strobe and a framing-error flag to the downstream interface logic.

Parameters:
- NBITS_DATA, 8, data bits per frame.
- OVERSAMPLE, 16, ticks per bit. Must be even and ≥4.
- STOPBITS_TCK, 16, ticks spent sampling the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial line, idle high.
- i_tick_brg  in  1  oversample tick, one i_clk cycle wide.
- o_data  out  NBITS_DATA  last received word, held until the next frame completes.
- o_rx_done  out  1  one-cycle pulse: o_data and o_frame_err updated.
- o_frame_err  out  1  stop bit sampled low on the last frame. Valid with o_rx_done, held until the next o_rx_done.

Behaviour:
- **Clock/reset:** reset i_reset, synchronous, active-high; clock i_clk.
- **Synchronizer:** i_rx passes through 2 flops; both reset to 1. FSM uses only the synchronized value rx_s. Latency is 2 i_clk cycles.
- **Reset values:** o_data=0, o_rx_done=0, o_frame_err=0, state=IDLE, all counters and the shift register 0.
- **Reset mid-frame:** frame discarded, no o_rx_done.
- **Counters:** tick counter width clog2(max(OVERSAMPLE, STOPBITS_TCK)); bit counter width clog2(NBITS_DATA). Each counts only on i_tick_brg. No action on non-tick cycles except IDLE edge detection.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: rx_s==0 (checked every clk, not only ticks) -> START, tick count=0.
  - START: on tick, if count==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 -> DATA, count=0, bit=0.
    - rx_s==1 -> glitch, back to IDLE, nothing reported.
    - Otherwise count++.
  - DATA: on tick, if count==OVERSAMPLE-1:
    - count=0; shift register = {rx_s, shreg[N-1:1]} (LSB first).
    - If bit==NBITS_DATA-1 -> STOP, else bit++.
    - Otherwise count++.
  - STOP: on tick, if count==STOPBITS_TCK-1:
    - Registered at the same edge: o_data<=shift register, o_frame_err<=~rx_s, o_rx_done<=1 for exactly one cycle.
    - Next state IDLE, count=0.
    - Otherwise count++.
- **Sample points:** each data sample lands mid-bit, OVERSAMPLE ticks after the previous one. The stop bit is sampled at the end of its STOPBITS_TCK window.
- **Back-to-back frames:** the next start edge is accepted the cycle after returning to IDLE.
- **Framing error:** o_rx_done still pulses and o_data still updates; the FSM does not hunt for resynchronization.
- **Line held low (break):** produces a frame of 0s with o_frame_err=1. Because the line is still low, a new frame starts immediately.
- **i_tick_brg stuck 0:** FSM holds its state indefinitely.
- **Latency:** o_rx_done rises 1 clk after the i_tick_brg that ends the stop window.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11), shared with the transmitter;
  - default OVERSAMPLE=16 and NBITS_DATA=8.
- Natural sub-module: sync_2ff, a 2-flop synchronizer with reset value parameter RST_VAL=1. It is reusable for other asynchronous inputs.
- The FSMD is a single module with a registered/next-state split.

Test Plan:
- Common bench setup: i_tick_brg pulses every 10 clk; bit time = 160 clk.
- Frame 0xA5, stop bit 1 -> exactly one o_rx_done pulse, o_data=0xA5, o_frame_err=0. The pulse occurs within the last stop-bit tick +1 clk.
- Frames 0x00 then 0xFF back-to-back, zero idle gap -> two pulses, o_data=0x00 then 0xFF, o_frame_err=0 both times.
- i_rx low for 5 ticks then high (glitch) -> no o_rx_done, FSM returns to IDLE. A following 0x3C frame is then received correctly.
- Frame 0x3C with stop bit driven 0 -> o_rx_done pulse, o_data=0x3C, o_frame_err=1. A following good frame 0x42 -> o_frame_err=0.
- i_reset asserted for 1 clk after 3 data bits of 0x81 -> no pulse, outputs 0. Next full frame 0x81 -> o_data=0x81.
- Loopback: connect to the team's transmitter with matching parameters (OVERSAMPLE=16, STOPBITS_TCK=16) and send 0x5A, 0xC3 -> received words match, o_frame_err=0.
